ibex_instr_bus_arbiter: RTL

- Shares the single core instruction-memory port (req/gnt/rvalid protocol) between two requesters: M0 = prefetch buffer, M1 = auxiliary fetcher (debug-ROM / boot loader fill).
- Arbitrates requests and holds the selection stable while an address phase is pending.
- Records the grant order in an ID FIFO and steers each rvalid/rdata/err back to the requester that issued it.
- Sits between the prefetch buffer and the core instruction bus.

---
 rtl/ibex_instr_arb_pkg.sv | 25 ++
 rtl/ibex_instr_bus_arbiter_if.sv | 14 +
 rtl/ibex_instr_arb_id_fifo.sv | 62 ++++++
 rtl/ibex_instr_bus_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/ibex_instr_arb_pkg.sv
// Shared types and sizing helpers for the instruction-bus arbiter.
// Contents: requester id enum, requester count, ID FIFO width helpers.
package ibex_instr_arb_pkg;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } instr_req_id_e;

  localparam int unsigned NumRequesters         = 2;
  localparam int unsigned DefaultMaxOutstanding = 2;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned id_fifo_ptr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width, able to hold 0..depth.
  function automatic int unsigned id_fifo_cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned IdFifoPtrW = id_fifo_ptr_w(DefaultMaxOutstanding);

endpackage

// File: rtl/ibex_instr_bus_arbiter_if.sv
// req/gnt/rvalid instruction-fetch bus bundle.
// master: drives req/addr, receives gnt/rvalid/rdata/err.
// slave:  receives req/addr, drives gnt/rvalid/rdata/err.
interface ibex_instr_bus_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ibex_instr_arb_id_fifo.sv
// Circular FIFO recording which requester owns each outstanding transaction.
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i, pop_i/data_o,
//        count_o (occupancy), full_o, empty_o.
// Push while full is accepted only when a pop happens in the same cycle.
module ibex_instr_arb_id_fifo
  import ibex_instr_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = id_fifo_cnt_w(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  instr_req_id_e   data_i,
  input  logic            pop_i,
  output instr_req_id_e   data_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PtrW = id_fifo_ptr_w(Depth);

  instr_req_id_e   mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are read only while occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Shares the core instruction port between the prefetch buffer (m0) and an
// auxiliary fetcher (m1). Holds selection while an address phase waits for
// gnt, records grant order and steers in-order responses back.
// Ports: clk_i, rst_i (sync, active-high), m0/m1 requester buses (slave),
//        instr downstream bus (master), busy_o, proto_err_o (sticky).
module ibex_instr_bus_arbiter
  import ibex_instr_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  ibex_instr_bus_arbiter_if.slave  m0,
  ibex_instr_bus_arbiter_if.slave  m1,
  ibex_instr_bus_arbiter_if.master instr,
  output logic                     busy_o,
  output logic                     proto_err_o
);

  localparam int unsigned CntW = id_fifo_cnt_w(MaxOutstanding);

  instr_req_id_e   sel, sel_q, rr_last_q, head_id;
  logic            lock_q, sel_req, slot_free, push, pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [31:0]     sel_addr;

  // Requester selection; a pending address phase pins it.
  always_comb begin
    sel = REQ_M0;
    if (lock_q) begin
      sel = sel_q;
    end else if (RoundRobin) begin
      if (m0.req && m1.req) sel = (rr_last_q == REQ_M0) ? REQ_M1 : REQ_M0;
      else if (m1.req)      sel = REQ_M1;
    end else if (!m0.req) begin
      sel = REQ_M1;
    end
  end

  assign sel_req  = (sel == REQ_M0) ? m0.req  : m1.req;
  assign sel_addr = (sel == REQ_M0) ? m0.addr : m1.addr;

  // A response popping this cycle frees its slot for a new grant at once.
  assign pop       = instr.rvalid & ~fifo_empty;
  assign slot_free = ~fifo_full | pop;

  assign instr.req  = sel_req & slot_free;
  assign instr.addr = sel_addr & 32'hFFFF_FFFC;
  assign push       = instr.req & instr.gnt;

  assign m0.gnt = push & (sel == REQ_M0);
  assign m1.gnt = push & (sel == REQ_M1);

  assign m0.rvalid = pop & (head_id == REQ_M0);
  assign m1.rvalid = pop & (head_id == REQ_M1);
  assign m0.rdata  = m0.rvalid ? instr.rdata : '0;
  assign m1.rdata  = m1.rvalid ? instr.rdata : '0;
  assign m0.err    = m0.rvalid & instr.err;
  assign m1.err    = m1.rvalid & instr.err;

  assign busy_o = instr.req | (fifo_count != '0);

  ibex_instr_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_id),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Lock, round-robin history and sticky orphan-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q      <= 1'b0;
      sel_q       <= REQ_M0;
      rr_last_q   <= REQ_M1;
      proto_err_o <= 1'b0;
    end else begin
      lock_q <= instr.req & ~instr.gnt;
      sel_q  <= sel;
      if (push) rr_last_q <= sel;
      if (instr.rvalid && fifo_empty) proto_err_o <= 1'b1;
    end
  end

endmodule
